// File: rtl/ahb_input_stage_pkg.sv
// Shared AHB encodings for the bus-matrix input stage.
// HTRANS, HBURST and HRESP constants.
package ahb_input_stage_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_input_stage.sv
// Per-master input stage of the L1 AHB matrix: forwards the address
// phase live or from a holding register and returns slave responses.
module ahb_input_stage
    import ahb_input_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  sel_dec,
    output logic [ADDR_WIDTH-1:0] addr_dec,
    output logic [1:0]            trans_dec,
    output logic                  write_dec,
    output logic [2:0]            size_dec,
    output logic [2:0]            burst_dec,
    output logic [3:0]            prot_dec,
    output logic                  lock_dec,
    input  logic                  active_dec,
    input  logic                  readyout_dec,
    input  logic                  resp_dec
);

    logic                  held;
    logic                  data_phase;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [1:0]            hold_trans;
    logic                  hold_write;
    logic [2:0]            hold_size;
    logic [2:0]            hold_burst;
    logic [3:0]            hold_prot;
    logic                  hold_lock;

    logic valid_in;
    logic issue;
    logic capture;
    logic rel;
    logic data_phase_next;

    always_comb begin
        valid_in = HSELS & HREADYS &
                   ((HTRANSS == HTRANS_NONSEQ) | (HTRANSS == HTRANS_SEQ));
        issue    = active_dec & readyout_dec;
        capture  = ~held & valid_in & ~issue;
        rel      = held & issue;
        // A data phase starts only when a real transfer is taken.
        if (issue & (held | valid_in)) begin
            data_phase_next = 1'b1;
        end else if (readyout_dec) begin
            data_phase_next = 1'b0;
        end else begin
            data_phase_next = data_phase;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            held       <= 1'b0;
            data_phase <= 1'b0;
            hold_addr  <= '0;
            hold_trans <= HTRANS_IDLE;
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_burst <= HBURST_SINGLE;
            hold_prot  <= '0;
            hold_lock  <= 1'b0;
        end else begin
            data_phase <= data_phase_next;
            if (capture) begin
                held       <= 1'b1;
                hold_addr  <= HADDRS;
                hold_trans <= HTRANSS;
                hold_write <= HWRITES;
                hold_size  <= HSIZES;
                hold_burst <= HBURSTS;
                hold_prot  <= HPROTS;
                hold_lock  <= HMASTLOCKS;
            end else if (rel) begin
                held <= 1'b0;
            end
        end
    end

    always_comb begin
        sel_dec   = HSELS & HREADYS;
        addr_dec  = HADDRS;
        trans_dec = HTRANSS;
        write_dec = HWRITES;
        size_dec  = HSIZES;
        burst_dec = HBURSTS;
        prot_dec  = HPROTS;
        lock_dec  = HMASTLOCKS;
        if (held) begin
            sel_dec   = 1'b1;
            addr_dec  = hold_addr;
            trans_dec = hold_trans;
            write_dec = hold_write;
            size_dec  = hold_size;
            burst_dec = hold_burst;
            prot_dec  = hold_prot;
            lock_dec  = hold_lock;
        end
    end

    // The master is stalled while a transfer sits in the holding register.
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        if (held) begin
            HREADYOUTS = 1'b0;
        end else if (data_phase) begin
            HREADYOUTS = readyout_dec;
            HRESPS     = resp_dec;
        end
    end

endmodule

// File: tb/tb_ahb_input_stage.sv
// Self-checking bench for ahb_input_stage: directed vector table
// followed by random traffic against a transaction-level model.
module tb_ahb_input_stage;
    import ahb_input_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hlock;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic        sel_dec;
    logic [31:0] addr_dec;
    logic [1:0]  trans_dec;
    logic        write_dec;
    logic [2:0]  size_dec;
    logic [2:0]  burst_dec;
    logic [3:0]  prot_dec;
    logic        lock_dec;
    logic        active;
    logic        rdy;
    logic        resp;

    int n_vec = 0;
    int n_err = 0;

    ahb_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HSELS(hsel), .HADDRS(haddr),
        .HTRANSS(htrans), .HWRITES(hwrite), .HSIZES(hsize),
        .HBURSTS(hburst), .HPROTS(hprot), .HMASTLOCKS(hlock),
        .HREADYS(hready), .HREADYOUTS(hreadyout), .HRESPS(hresp),
        .sel_dec(sel_dec), .addr_dec(addr_dec), .trans_dec(trans_dec),
        .write_dec(write_dec), .size_dec(size_dec),
        .burst_dec(burst_dec), .prot_dec(prot_dec),
        .lock_dec(lock_dec), .active_dec(active),
        .readyout_dec(rdy), .resp_dec(resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write, lock, hready, active, rdy, resp;
        logic        e_hrdy, e_hresp, e_sel;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_lock;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } xfer_t;

    localparam logic [1:0] I = HTRANS_IDLE;
    localparam logic [1:0] N = HTRANS_NONSEQ;
    localparam logic [1:0] S = HTRANS_SEQ;

    vec_t tbl[24];

    function automatic vec_t mk(
        input logic r, input logic s, input logic [1:0] t,
        input logic [31:0] a, input logic w, input logic l,
        input logic hr, input logic ac, input logic rd, input logic rs,
        input logic eh, input logic er, input logic es,
        input logic [1:0] et, input logic [31:0] ea, input logic el);
        vec_t v;
        v.rst_n = r;  v.sel = s;  v.trans = t;  v.addr = a;
        v.write = w;  v.lock = l; v.hready = hr; v.active = ac;
        v.rdy = rd;   v.resp = rs;
        v.e_hrdy = eh; v.e_hresp = er; v.e_sel = es;
        v.e_trans = et; v.e_addr = ea; v.e_lock = el;
        return v;
    endfunction

    xfer_t pend[$];
    logic  m_dp;

    task automatic drive_idle();
        rst_n = 1'b1; hsel = 1'b0; haddr = '0; htrans = I;
        hwrite = 1'b0; hsize = '0; hburst = '0; hprot = '0;
        hlock = 1'b0; hready = 1'b1; active = 1'b0;
        rdy = 1'b1; resp = 1'b0;
    endtask

    task automatic check_model(input int cyc);
        xfer_t e;
        logic  e_sel, e_hrdy, e_hresp;
        e.addr = haddr; e.trans = htrans; e.write = hwrite;
        e.size = hsize; e.burst = hburst; e.prot = hprot; e.lock = hlock;
        e_sel   = hsel & hready;
        e_hrdy  = m_dp ? rdy : 1'b1;
        e_hresp = m_dp ? resp : 1'b0;
        if (pend.size() != 0) begin
            e = pend[0];
            e_sel = 1'b1; e_hrdy = 1'b0; e_hresp = 1'b0;
        end
        n_vec++;
        if ({hreadyout, hresp, sel_dec, addr_dec, trans_dec, write_dec,
             size_dec, burst_dec, prot_dec, lock_dec} !==
            {e_hrdy, e_hresp, e_sel, e.addr, e.trans, e.write,
             e.size, e.burst, e.prot, e.lock}) begin
            n_err++;
            $display("FAIL rand[%0d]: got rdy=%b rsp=%b sel=%b a=%h t=%0d w=%b sz=%0d b=%0d p=%0d l=%b want rdy=%b rsp=%b sel=%b a=%h t=%0d w=%b sz=%0d b=%0d p=%0d l=%b",
                cyc, hreadyout, hresp, sel_dec, addr_dec, trans_dec,
                write_dec, size_dec, burst_dec, prot_dec, lock_dec,
                e_hrdy, e_hresp, e_sel, e.addr, e.trans, e.write,
                e.size, e.burst, e.prot, e.lock);
        end
    endtask

    task automatic model_step();
        logic taken, wants, live_valid;
        xfer_t x;
        if (!rst_n) begin
            pend.delete();
            m_dp = 1'b0;
            return;
        end
        live_valid = hsel & hready & htrans[1];
        taken = active & rdy;
        wants = (pend.size() != 0) | live_valid;
        if (taken && wants)  m_dp = 1'b1;
        else if (rdy)        m_dp = 1'b0;
        if (pend.size() != 0) begin
            if (taken) void'(pend.pop_front());
        end else if (live_valid && !taken) begin
            x.addr = haddr; x.trans = htrans; x.write = hwrite;
            x.size = hsize; x.burst = hburst; x.prot = hprot;
            x.lock = hlock;
            pend.push_back(x);
        end
    endtask

    initial begin
        //          r s t  addr          w l hr ac rd rs | eh er es et ea           el
        tbl[0]  = mk(1,0,I,32'h0,        0,0,1, 0, 1, 0,  1, 0, 0, I, 32'h0,       0);
        tbl[1]  = mk(1,1,N,32'h2000_0000,1,0,1, 1, 1, 0,  1, 0, 1, N, 32'h2000_0000,0);
        tbl[2]  = mk(1,0,I,32'h0,        0,0,1, 1, 1, 0,  1, 0, 0, I, 32'h0,       0);
        tbl[3]  = mk(1,1,N,32'h0000_0100,0,0,1, 0, 1, 0,  1, 0, 1, N, 32'h0000_0100,0);
        tbl[4]  = mk(1,1,N,32'h0000_0100,0,0,0, 0, 1, 0,  0, 0, 1, N, 32'h0000_0100,0);
        tbl[5]  = mk(1,1,N,32'h0000_0100,0,0,0, 1, 1, 0,  0, 0, 1, N, 32'h0000_0100,0);
        tbl[6]  = mk(1,0,I,32'h0,        0,0,0, 1, 0, 0,  0, 0, 0, I, 32'h0,       0);
        tbl[7]  = mk(1,0,I,32'h0,        0,0,0, 1, 1, 0,  1, 0, 0, I, 32'h0,       0);
        tbl[8]  = mk(1,1,N,32'h3000_0000,0,0,1, 1, 1, 0,  1, 0, 1, N, 32'h3000_0000,0);
        tbl[9]  = mk(1,0,I,32'h0,        0,0,1, 1, 0, 1,  0, 1, 0, I, 32'h0,       0);
        tbl[10] = mk(1,0,I,32'h0,        0,0,1, 1, 1, 1,  1, 1, 0, I, 32'h0,       0);
        tbl[11] = mk(1,0,I,32'h0,        0,0,1, 1, 1, 0,  1, 0, 0, I, 32'h0,       0);
        tbl[12] = mk(1,1,N,32'h4000_0000,0,1,1, 0, 1, 0,  1, 0, 1, N, 32'h4000_0000,1);
        tbl[13] = mk(1,1,N,32'hDEAD_0000,0,0,0, 1, 1, 0,  0, 0, 1, N, 32'h4000_0000,1);
        tbl[14] = mk(1,0,I,32'h0,        0,0,1, 1, 1, 0,  1, 0, 0, I, 32'h0,       0);
        tbl[15] = mk(1,1,N,32'h5000_0000,0,0,1, 0, 1, 0,  1, 0, 1, N, 32'h5000_0000,0);
        tbl[16] = mk(0,0,I,32'h0,        0,0,0, 0, 1, 0,  0, 0, 1, N, 32'h5000_0000,0);
        tbl[17] = mk(1,0,I,32'h0,        0,0,1, 0, 0, 1,  1, 0, 0, I, 32'h0,       0);
        tbl[18] = mk(1,1,N,32'h0000_0600,0,0,1, 1, 1, 0,  1, 0, 1, N, 32'h0000_0600,0);
        tbl[19] = mk(1,1,S,32'h0000_0604,0,0,1, 1, 0, 0,  0, 0, 1, S, 32'h0000_0604,0);
        tbl[20] = mk(1,1,S,32'h0000_0604,0,0,0, 1, 1, 0,  0, 0, 1, S, 32'h0000_0604,0);
        tbl[21] = mk(1,1,S,32'h0000_0608,0,0,1, 1, 1, 0,  1, 0, 1, S, 32'h0000_0608,0);
        tbl[22] = mk(1,1,S,32'h0000_060C,0,0,1, 1, 1, 0,  1, 0, 1, S, 32'h0000_060C,0);
        tbl[23] = mk(1,0,I,32'h0,        0,0,1, 1, 1, 0,  1, 0, 0, I, 32'h0,       0);

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; hsel = tbl[i].sel;
            htrans = tbl[i].trans; haddr = tbl[i].addr;
            hwrite = tbl[i].write; hlock = tbl[i].lock;
            hready = tbl[i].hready; active = tbl[i].active;
            rdy = tbl[i].rdy; resp = tbl[i].resp;
            hsize = 3'd2; hburst = HBURST_INCR4; hprot = 4'h3;
            #1;
            n_vec++;
            if ({hreadyout, hresp, sel_dec, trans_dec, addr_dec, lock_dec} !==
                {tbl[i].e_hrdy, tbl[i].e_hresp, tbl[i].e_sel,
                 tbl[i].e_trans, tbl[i].e_addr, tbl[i].e_lock}) begin
                n_err++;
                $display("FAIL vec[%0d]: got rdy=%b rsp=%b sel=%b t=%0d a=%h l=%b want rdy=%b rsp=%b sel=%b t=%0d a=%h l=%b",
                    i, hreadyout, hresp, sel_dec, trans_dec, addr_dec,
                    lock_dec, tbl[i].e_hrdy, tbl[i].e_hresp, tbl[i].e_sel,
                    tbl[i].e_trans, tbl[i].e_addr, tbl[i].e_lock);
            end
        end

        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        pend.delete();
        m_dp = 1'b0;
        @(posedge clk);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst_n  = ($urandom_range(0, 59) != 0);
            hsel   = ($urandom_range(0, 3) != 0);
            htrans = 2'($urandom_range(0, 3));
            haddr  = $urandom;
            hwrite = 1'($urandom_range(0, 1));
            hsize  = 3'($urandom_range(0, 7));
            hburst = 3'($urandom_range(0, 7));
            hprot  = 4'($urandom_range(0, 15));
            hlock  = 1'($urandom_range(0, 1));
            hready = ($urandom_range(0, 4) != 0);
            active = ($urandom_range(0, 2) != 0);
            rdy    = ($urandom_range(0, 3) != 0);
            resp   = ($urandom_range(0, 5) == 0);
            #1;
            check_model(c);
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
